// File: rtl/result_binarize_packer.sv
// result_binarize_packer: thresholds N*N BRAM results into a 1-bit image,
// packs 8 pixels per byte MSB-first, streams header + bytes + XOR checksum.
module result_binarize_packer #(
    parameter int         N      = 12,
    parameter int         DW     = 32,
    parameter int         AW     = 8,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] threshold,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_dout,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_done_tick,
    output logic          busy,
    output logic          done
);
    localparam int NN = N * N;
    localparam int CW = $clog2(NN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_CAP,
        S_BYTE_TX,
        S_CSUM_TX,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] thr_q, thr_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    csum_q, csum_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic       pixel;
    logic       last_pix;
    logic       tx_ack;
    logic [7:0] shifted;
    logic [7:0] packed_byte;

    assign pixel    = (bram_dout > thr_q);
    assign last_pix = (pix_cnt_q == CW'(NN - 1));
    assign shifted  = {byte_q[6:0], pixel};
    // A short final byte is left-justified; a full byte shifts by zero.
    assign packed_byte = shifted << (3'd7 - bit_cnt_q);
    // A tick only counts while our own request is outstanding.
    assign tx_ack = tx_start_q & tx_done_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            thr_q      <= '0;
            pix_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            pix_cnt_q  <= pix_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        pix_cnt_d  = pix_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_d     = threshold;
                    pix_cnt_d = '0;
                    bit_cnt_d = '0;
                    byte_d    = '0;
                    csum_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                tx_data_d  = HEADER;
                tx_start_d = 1'b1;
                if (tx_ack) begin
                    tx_start_d = 1'b0;
                    state_d    = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                addr_d  = AW'(pix_cnt_q);
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                byte_d    = shifted;
                pix_cnt_d = pix_cnt_q + CW'(1);
                bit_cnt_d = bit_cnt_q + 3'd1;
                state_d   = S_RD_ADDR;
                if (bit_cnt_q == 3'd7 || last_pix) begin
                    tx_data_d  = packed_byte;
                    tx_start_d = 1'b1;
                    csum_d     = csum_q ^ packed_byte;
                    bit_cnt_d  = '0;
                    byte_d     = '0;
                    state_d    = S_BYTE_TX;
                end
            end
            S_BYTE_TX: begin
                if (tx_ack) begin
                    tx_start_d = 1'b0;
                    state_d = (pix_cnt_q == CW'(NN)) ? S_CSUM_TX
                                                     : S_RD_ADDR;
                end
            end
            S_CSUM_TX: begin
                tx_data_d  = csum_q;
                tx_start_d = 1'b1;
                if (tx_ack) begin
                    tx_start_d = 1'b0;
                    state_d    = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bram_addr = addr_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_result_binarize_packer.sv
// Bench for result_binarize_packer: N=12 and N=5 instances, BRAM and
// UART models, table of frame vectors plus reset/restart sequences.
module tb_result_binarize_packer;
    typedef struct {
        bit          idx;
        logic [31:0] val;
        logic [31:0] thr;
        logic [7:0]  b0;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  cs;
    } vec_t;

    localparam int UL = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start        [2];
    logic [31:0] thr          [2];
    logic [7:0]  bram_addr    [2];
    logic [31:0] bram_dout    [2];
    logic        tx_start     [2];
    logic [7:0]  tx_data      [2];
    logic        tx_done_tick [2];
    logic        busy         [2];
    logic        done         [2];

    logic [31:0] mem [2][256];
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    logic [7:0]  cap  [2];
    int          ust  [2];
    int          ucnt [2];
    int          done_cnt [2] = '{0, 0};
    int          hold_err = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        vt [10];

    always #5 clk = ~clk;

    result_binarize_packer #(.N(12)) u_dut12 (
        .clk(clk), .reset(reset), .start(start[0]),
        .threshold(thr[0]), .bram_addr(bram_addr[0]),
        .bram_dout(bram_dout[0]), .tx_start(tx_start[0]),
        .tx_data(tx_data[0]), .tx_done_tick(tx_done_tick[0]),
        .busy(busy[0]), .done(done[0])
    );

    result_binarize_packer #(.N(5)) u_dut5 (
        .clk(clk), .reset(reset), .start(start[1]),
        .threshold(thr[1]), .bram_addr(bram_addr[1]),
        .bram_dout(bram_dout[1]), .tx_start(tx_start[1]),
        .tx_data(tx_data[1]), .tx_done_tick(tx_done_tick[1]),
        .busy(busy[1]), .done(done[1])
    );

    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            bram_dout[k] <= mem[k][bram_addr[k]];

    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;

    // UART: capture on request, tick after UL cycles, then wait for drop.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                ust[k] <= 0;
                ucnt[k] <= 0;
                tx_done_tick[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                tx_done_tick[k] <= 1'b0;
                case (ust[k])
                    0: if (tx_start[k]) begin
                        if (k == 0) q0.push_back(tx_data[k]);
                        else q1.push_back(tx_data[k]);
                        cap[k] <= tx_data[k];
                        ucnt[k] <= UL;
                        ust[k] <= 1;
                    end
                    1: begin
                        if (!tx_start[k] || tx_data[k] !== cap[k])
                            hold_err <= hold_err + 1;
                        if (ucnt[k] == 1) begin
                            tx_done_tick[k] <= 1'b1;
                            ust[k] <= 2;
                        end else ucnt[k] <= ucnt[k] - 1;
                    end
                    default: if (!tx_start[k]) ust[k] <= 0;
                endcase
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic frame12(input int i, input bit poke);
        int base;
        int d0;
        logic [7:0] e;
        logic [31:0] a;
        for (int x = 0; x < 256; x++)
            mem[0][x] = vt[i].idx ? 32'(x) : vt[i].val;
        @(negedge clk);
        base = q0.size();
        d0 = done_cnt[0];
        thr[0] = vt[i].thr;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        thr[0] = ~vt[i].thr;
        repeat (10) @(negedge clk);
        check($sformatf("v%0d busy", i), 32'(busy[0]), 32'd1);
        for (int c = 0; c < 6000 && done_cnt[0] == d0; c++) begin
            @(negedge clk);
            start[0] = poke && (c == 200);
        end
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        check($sformatf("v%0d done", i), 32'(done_cnt[0] - d0), 32'd1);
        check($sformatf("v%0d idle", i), 32'(busy[0]), 32'd0);
        check($sformatf("v%0d len", i), 32'(q0.size() - base), 32'd20);
        for (int j = 0; j < 20; j++) begin
            e = (j == 0) ? 8'hA5 : (j == 1) ? vt[i].b0 :
                (j <= 9) ? vt[i].lo : (j <= 18) ? vt[i].hi : vt[i].cs;
            a = (base + j < q0.size()) ? 32'(q0[base + j]) : 32'hDEAD_BEEF;
            check($sformatf("v%0d byte%0d", i, j), a, 32'(e));
        end
    endtask

    task automatic frame5();
        int base;
        int d0;
        logic [7:0] exp5 [6];
        logic [31:0] a;
        // 25 pixels: FF FF FF then one pixel left-justified; FF^FF^FF^80 = 7F
        exp5 = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h7F};
        for (int x = 0; x < 256; x++) mem[1][x] = 32'd1;
        @(negedge clk);
        base = q1.size();
        d0 = done_cnt[1];
        thr[1] = 32'd0;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int c = 0; c < 3000 && done_cnt[1] == d0; c++)
            @(negedge clk);
        repeat (20) @(negedge clk);
        check("n5 done", 32'(done_cnt[1] - d0), 32'd1);
        check("n5 len", 32'(q1.size() - base), 32'd6);
        for (int j = 0; j < 6; j++) begin
            a = (base + j < q1.size()) ? 32'(q1[base + j]) : 32'hDEAD_BEEF;
            check($sformatf("n5 byte%0d", j), a, 32'(exp5[j]));
        end
    endtask

    task automatic reset_mid_frame();
        int base;
        bit hit;
        for (int x = 0; x < 256; x++) mem[0][x] = 32'(x);
        @(negedge clk);
        base = q0.size();
        thr[0] = 32'd0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            hit = (q0.size() >= base + 3) && tx_start[0];
        end
        check("rst reached byte", 32'(hit), 32'd1);
        reset = 1'b1;
        #1;
        check("rst tx_start", 32'(tx_start[0]), 32'd0);
        check("rst busy", 32'(busy[0]), 32'd0);
        check("rst addr", 32'(bram_addr[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base = q0.size();
        repeat (40) @(negedge clk);
        check("rst no resume", 32'(q0.size() - base), 32'd0);
        check("rst stays idle", 32'(busy[0]), 32'd0);
    endtask

    initial begin
        vt[0] = '{1'b0, 32'd0,    32'd0,    8'h00, 8'h00, 8'h00, 8'h00};
        vt[1] = '{1'b0, 32'd1000, 32'd999,  8'hFF, 8'hFF, 8'hFF, 8'h00};
        vt[2] = '{1'b1, 32'd0,    32'd71,   8'h00, 8'h00, 8'hFF, 8'hFF};
        vt[3] = '{1'b0, 32'd5,    32'd5,    8'h00, 8'h00, 8'h00, 8'h00};
        vt[4] = '{1'b0, 32'd6,    32'd5,    8'hFF, 8'hFF, 8'hFF, 8'h00};
        vt[5] = '{1'b1, 32'd0,    32'd0,    8'h7F, 8'hFF, 8'hFF, 8'h80};
        vt[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                  8'hFF, 8'hFF, 8'hFF, 8'h00};
        vt[7] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF,
                  8'hFF, 8'hFF, 8'hFF, 8'h00};
        vt[8] = '{1'b0, 32'h7FFF_FFFF, 32'h8000_0000,
                  8'h00, 8'h00, 8'h00, 8'h00};
        vt[9] = '{1'b1, 32'd0,    32'd143,  8'h00, 8'h00, 8'h00, 8'h00};

        reset = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        thr[0] = '0;
        thr[1] = '0;
        repeat (3) @(negedge clk);
        check("reset addr", 32'(bram_addr[0]), 32'd0);
        check("reset tx_start", 32'(tx_start[0]), 32'd0);
        check("reset tx_data", 32'(tx_data[0]), 32'd0);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset done", 32'(done[0]), 32'd0);
        check("reset busy n5", 32'(busy[1]), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) frame12(i, i == 2);
        frame5();
        reset_mid_frame();
        frame12(5, 1'b0);
        check("tx handshake hold", 32'(hold_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
